res_to_bcd: RTL

- Sequential binary-to-BCD converter for the calculator datapath. It sits directly downstream of the subtract/add result stage.
- It captures the 40-bit magnitude, the sign and the error flag, range-checks them, and converts the magnitude to 6 BCD digits using iterative double-dabble.
- It produces a leading-zero blank mask plus minus and error indicators for the display multiplexer.
- It uses a start/done handshake; one conversion is in flight at a time.

---
 rtl/res_to_bcd.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/res_to_bcd.sv
// Sequential binary-to-BCD converter with range check, sign and blank-mask outputs.
// Define RES_TO_BCD_LZB_EN to enable leading-zero blanking.
module res_to_bcd #(
    parameter int unsigned IN_W      = 40,
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned LIM_POS   = 999999,
    parameter int unsigned LIM_NEG   = 99999,
    parameter int unsigned CONV_BITS = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [IN_W-1:0]       i_val,
    input  logic                  i_sign,
    input  logic                  i_err,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIGITS*4-1:0]   o_bcd,
    output logic [DIGITS-1:0]     o_blank,
    output logic                  o_neg,
    output logic                  o_err
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned SR_W  = BCD_W + CONV_BITS;
    localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);

`ifdef RES_TO_BCD_LZB_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS - 1){1'b1}}, 1'b0};
`else
    localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StShift,
        StBlank,
        StDone
    } state_t;

    state_t            state_q;
    logic [IN_W-1:0]   val_q;
    logic              sign_q;
    logic              err_q;
    logic [SR_W-1:0]   sr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [SR_W-1:0]   sr_adj;
    logic [SR_W-1:0]   sr_shift;
    logic [BCD_W-1:0]  bcd_res;
    logic [DIGITS-1:0] blank_mask;
    logic              range_err;

    assign o_busy = (state_q != StIdle);

    // Double-dabble step: correct each nibble >= 5 before the shift.
    always_comb begin
        sr_adj = sr_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (sr_q[CONV_BITS + 4*k +: 4] >= 4'd5) begin
                sr_adj[CONV_BITS + 4*k +: 4] = sr_q[CONV_BITS + 4*k +: 4] + 4'd3;
            end
        end
        sr_shift = {sr_adj[SR_W-2:0], 1'b0};
    end

    assign bcd_res = sr_q[SR_W-1 -: BCD_W];

`ifdef RES_TO_BCD_LZB_EN
    logic zero_above;
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            zero_above    = zero_above & (bcd_res[4*k +: 4] == 4'd0);
            blank_mask[k] = zero_above;
        end
    end
`else
    assign blank_mask = '0;
`endif

    // Full-width compares: any bit above the converted range is an error.
    assign range_err = err_q
                     | ( sign_q & (val_q > IN_W'(LIM_NEG)))
                     | (!sign_q & (val_q > IN_W'(LIM_POS)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            val_q   <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            sr_q    <= '0;
            cnt_q   <= '0;
            o_done  <= 1'b0;
            o_bcd   <= '0;
            o_blank <= BLANK_RST;
            o_neg   <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        val_q   <= i_val;
                        sign_q  <= i_sign;
                        err_q   <= i_err;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (range_err) begin
                        o_err   <= 1'b1;
                        o_bcd   <= '0;
                        o_blank <= '1;
                        o_neg   <= 1'b0;
                        o_done  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        sr_q    <= {{BCD_W{1'b0}}, val_q[CONV_BITS-1:0]};
                        cnt_q   <= CNT_W'(CONV_BITS);
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    sr_q  <= sr_shift;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StBlank;
                    end
                end
                StBlank: begin
                    o_bcd   <= bcd_res;
                    o_blank <= blank_mask;
                    o_neg   <= sign_q & (bcd_res != '0);
                    o_err   <= 1'b0;
                    o_done  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    // A start here is taken as edge 0 of the next conversion.
                    o_done <= 1'b0;
                    if (i_start) begin
                        val_q   <= i_val;
                        sign_q  <= i_sign;
                        err_q   <= i_err;
                        state_q <= StCheck;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
